// File: rtl/mem_access_seq.sv
// mem_access_seq: memory transaction sequencer for the simple computer datapath.
//
// Takes a read or write request from the CPU control FSM (sampled in IDLE only)
// and steps through MAR load, SRAM strobing with a parameterised number of wait
// states, and MDR load. It reports Busy while active and pulses Done for one
// cycle when the transaction completes.
//
// Parameters:
//   READ_WAIT  - cycles OE_n is held low before MDR captures memory data (1..15)
//   WRITE_WAIT - cycles WE_n is held low for a write (1..15)
//
// Ports:
//   Clk        - system clock, rising edge
//   Reset      - synchronous, active-high
//   Req_Read   - read request level, sampled in IDLE
//   Req_Write  - write request level, sampled in IDLE (read wins on conflict)
//   LD_MAR     - load MAR from bus
//   LD_MDR     - load MDR
//   MIO_EN     - MDR source select: 1 = memory data, 0 = bus
//   Mem_CE_n   - SRAM chip enable, active-low
//   Mem_OE_n   - SRAM output enable, active-low
//   Mem_WE_n   - SRAM write enable, active-low
//   Busy       - high whenever state != IDLE
//   Done       - one-cycle completion pulse
//   State_Dbg  - current state encoding
module mem_access_seq #(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req_Read,
  input  logic       Req_Write,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       MIO_EN,
  output logic       Mem_CE_n,
  output logic       Mem_OE_n,
  output logic       Mem_WE_n,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] State_Dbg
);

  if (READ_WAIT < 1 || READ_WAIT > 15) begin : g_bad_read_wait
    $error("mem_access_seq: READ_WAIT must be in 1..15");
  end
  if (WRITE_WAIT < 1 || WRITE_WAIT > 15) begin : g_bad_write_wait
    $error("mem_access_seq: WRITE_WAIT must be in 1..15");
  end

  localparam logic [3:0] RD_LAST = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LAST = 4'(WRITE_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_MAR = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_CAPTURE  = 3'd3,
    S_LOAD_MDR = 3'd4,
    S_WR_PULSE = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t     state, nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       rd_flag, rd_flag_nxt;

  // Decoded values for the state about to be entered; registering these gives
  // Moore outputs that line up with the state register, with no input path.
  logic       d_ld_mar, d_ld_mdr, d_mio_en, d_ce_n, d_oe_n, d_we_n, d_busy, d_done;

  always_comb begin
    nxt         = state;
    cnt_nxt     = cnt;
    rd_flag_nxt = rd_flag;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (Req_Read) begin
          nxt         = S_LOAD_MAR;
          rd_flag_nxt = 1'b1;
        end else if (Req_Write) begin
          nxt         = S_LOAD_MAR;
          rd_flag_nxt = 1'b0;
        end
      end
      S_LOAD_MAR: begin
        cnt_nxt = '0;
        nxt     = rd_flag ? S_RD_WAIT : S_LOAD_MDR;
      end
      S_RD_WAIT: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == RD_LAST) nxt = S_CAPTURE;
      end
      S_CAPTURE:  nxt = S_DONE;
      S_LOAD_MDR: begin
        cnt_nxt = '0;
        nxt     = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == WR_LAST) nxt = S_DONE;
      end
      S_DONE:     nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  always_comb begin
    d_ld_mar = 1'b0;
    d_ld_mdr = 1'b0;
    d_mio_en = 1'b0;
    d_ce_n   = 1'b1;
    d_oe_n   = 1'b1;
    d_we_n   = 1'b1;
    d_busy   = (nxt != S_IDLE);
    d_done   = 1'b0;
    case (nxt)
      S_LOAD_MAR: d_ld_mar = 1'b1;
      S_RD_WAIT: begin
        d_ce_n = 1'b0;
        d_oe_n = 1'b0;
      end
      S_CAPTURE: begin
        d_ce_n   = 1'b0;
        d_oe_n   = 1'b0;
        d_ld_mdr = 1'b1;
        d_mio_en = 1'b1;
      end
      S_LOAD_MDR: d_ld_mdr = 1'b1;
      S_WR_PULSE: begin
        d_ce_n = 1'b0;
        d_we_n = 1'b0;
      end
      S_DONE:  d_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rd_flag   <= 1'b0;
      LD_MAR    <= 1'b0;
      LD_MDR    <= 1'b0;
      MIO_EN    <= 1'b0;
      Mem_CE_n  <= 1'b1;
      Mem_OE_n  <= 1'b1;
      Mem_WE_n  <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      State_Dbg <= 3'd0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      rd_flag   <= rd_flag_nxt;
      LD_MAR    <= d_ld_mar;
      LD_MDR    <= d_ld_mdr;
      MIO_EN    <= d_mio_en;
      Mem_CE_n  <= d_ce_n;
      Mem_OE_n  <= d_oe_n;
      Mem_WE_n  <= d_we_n;
      Busy      <= d_busy;
      Done      <= d_done;
      State_Dbg <= nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: default-parameter instance plus a READ_WAIT=1 /
// WRITE_WAIT=5 instance. Expected per-cycle output vectors are derived from the
// documented transaction timeline and queued when a request is driven; each
// cycle after the active edge one entry is popped and compared.
module tb_mem_access_seq;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       rr0, rw0, rr1, rw1;
  logic       ld_mar0, ld_mdr0, mio0, ce0, oe0, we0, busy0, done0;
  logic       ld_mar1, ld_mdr1, mio1, ce1, oe1, we1, busy1, done1;
  logic [2:0] st0, st1;

  always #5 Clk = ~Clk;

  mem_access_seq dut0 (
    .Clk(Clk), .Reset(Reset), .Req_Read(rr0), .Req_Write(rw0),
    .LD_MAR(ld_mar0), .LD_MDR(ld_mdr0), .MIO_EN(mio0),
    .Mem_CE_n(ce0), .Mem_OE_n(oe0), .Mem_WE_n(we0),
    .Busy(busy0), .Done(done0), .State_Dbg(st0)
  );

  mem_access_seq #(.READ_WAIT(1), .WRITE_WAIT(5)) dut1 (
    .Clk(Clk), .Reset(Reset), .Req_Read(rr1), .Req_Write(rw1),
    .LD_MAR(ld_mar1), .LD_MDR(ld_mdr1), .MIO_EN(mio1),
    .Mem_CE_n(ce1), .Mem_OE_n(oe1), .Mem_WE_n(we1),
    .Busy(busy1), .Done(done1), .State_Dbg(st1)
  );

  // {State_Dbg, LD_MAR, LD_MDR, MIO_EN, CE_n, OE_n, WE_n, Busy, Done}
  logic [10:0] obs0, obs1;
  assign obs0 = {st0, ld_mar0, ld_mdr0, mio0, ce0, oe0, we0, busy0, done0};
  assign obs1 = {st1, ld_mar1, ld_mdr1, mio1, ce1, oe1, we1, busy1, done1};

  typedef struct {
    string       tag;
    logic [10:0] v;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [10:0] mk(input logic [2:0] s, input logic mar, input logic mdr,
                                     input logic mio, input logic ce, input logic oe,
                                     input logic we, input logic busy, input logic done);
    return {s, mar, mdr, mio, ce, oe, we, busy, done};
  endfunction

  function automatic logic [10:0] idle_v();
    return mk(3'd0, 0, 0, 0, 1, 1, 1, 0, 0);
  endfunction

  task automatic push(input string tag, input logic [10:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    expq.push_back(e);
  endtask

  // Full transaction timeline from the cycle after the sampling edge,
  // ending with one IDLE cycle.
  task automatic push_txn(input string tag, input bit rd, input int wt);
    push({tag, "_ldmar"}, mk(3'd1, 1, 0, 0, 1, 1, 1, 1, 0));
    if (rd) begin
      for (int i = 0; i < wt; i++) push({tag, "_rdwait"}, mk(3'd2, 0, 0, 0, 0, 0, 1, 1, 0));
      push({tag, "_capture"}, mk(3'd3, 0, 1, 1, 0, 0, 1, 1, 0));
    end else begin
      push({tag, "_ldmdr"}, mk(3'd4, 0, 1, 0, 1, 1, 1, 1, 0));
      for (int i = 0; i < wt; i++) push({tag, "_wrpulse"}, mk(3'd5, 0, 0, 0, 0, 1, 0, 1, 0));
    end
    push({tag, "_done"}, mk(3'd6, 0, 0, 0, 1, 1, 1, 1, 1));
    push({tag, "_idle"}, idle_v());
  endtask

  task automatic check_n(input int which, input int n);
    exp_t        e;
    logic [10:0] o;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (expq.size() == 0) begin
        total++;
        bad++;
        $error("FAIL scoreboard_empty obs=%b exp=<entry>", (which == 0) ? obs0 : obs1);
      end else begin
        e = expq.pop_front();
        o = (which == 0) ? obs0 : obs1;
        total++;
        assert (o === e.v) else begin
          bad++;
          $error("FAIL %s obs=%b exp=%b", e.tag, o, e.v);
        end
      end
    end
  endtask

  // Drive a one-edge request pulse from a negedge, then check the timeline.
  task automatic run_txn(input int which, input bit rd, input bit wr, input string tag,
                         input bit exp_rd, input int wt);
    @(negedge Clk);
    if (which == 0) begin rr0 = rd; rw0 = wr; end
    else            begin rr1 = rd; rw1 = wr; end
    push_txn(tag, exp_rd, wt);
    @(posedge Clk);
    #1;
    rr0 = 1'b0; rw0 = 1'b0; rr1 = 1'b0; rw1 = 1'b0;
    check_n(which, wt + 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    rr0 = 1'b1; rw0 = 1'b0; rr1 = 1'b0; rw1 = 1'b0;

    // Reset held two cycles with a read request pending.
    @(posedge Clk);
    push("reset_c1", idle_v());
    check_n(0, 1);
    push("reset_c2", idle_v());
    check_n(0, 1);
    Reset = 1'b0;
    // Next edge samples the still-held read.
    push_txn("post_reset_rd", 1'b1, 2);
    @(posedge Clk);
    #1;
    rr0 = 1'b0;
    check_n(0, 6);

    // Default read and write.
    run_txn(0, 1'b1, 1'b0, "rd_def", 1'b1, 2);
    run_txn(0, 1'b0, 1'b1, "wr_def", 1'b0, 2);

    // Conflict, held: read wins, back-to-back with one idle cycle between.
    @(negedge Clk);
    rr0 = 1'b1; rw0 = 1'b1;
    push_txn("conf1", 1'b1, 2);
    push_txn("conf2", 1'b1, 2);
    push_txn("conf3", 1'b1, 2);
    push("conf_idle", idle_v());
    check_n(0, 17);
    rr0 = 1'b0; rw0 = 1'b0;
    check_n(0, 2);

    // Reset while in RD_WAIT: no Done afterwards.
    @(negedge Clk);
    rr0 = 1'b1;
    push("mid_ldmar",  mk(3'd1, 1, 0, 0, 1, 1, 1, 1, 0));
    push("mid_rdwait", mk(3'd2, 0, 0, 0, 0, 0, 1, 1, 0));
    @(posedge Clk);
    #1;
    rr0 = 1'b0;
    check_n(0, 2);
    Reset = 1'b1;
    push("mid_rst", idle_v());
    check_n(0, 1);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) push("mid_after", idle_v());
    check_n(0, 4);

    // Parameter sweep instance.
    run_txn(1, 1'b1, 1'b0, "rd_w1", 1'b1, 1);
    run_txn(1, 1'b0, 1'b1, "wr_w5", 1'b0, 5);
    run_txn(1, 1'b1, 1'b1, "conf_w1", 1'b1, 1);

    total++;
    assert (expq.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain obs=%0d exp=0", expq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
